// File: rtl/data_sram_responder.sv
// Data-SRAM responder: byte-writable word RAM plus a config window (LED, NUM, SWITCH, TIMER).
// Latency: reads return on sram_rdata one cycle after the request; writes complete at the request edge.
// Backpressure: none; an access is accepted every cycle, and sram_rdata holds across writes and idles.
module data_sram_responder #(
    parameter int          RAM_AW    = 12,
    parameter logic [15:0] CONF_BASE = 16'h1faf,
    parameter int          SW_W      = 8
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            sram_en,
    input  logic [3:0]      sram_wen,
    input  logic [31:0]     sram_addr,
    input  logic [31:0]     sram_wdata,
    output logic [31:0]     sram_rdata,
    input  logic [SW_W-1:0] switch_in,
    output logic [15:0]     led_out,
    output logic [31:0]     num_out
);

    localparam logic [15:0] OFF_LED   = 16'hf000;
    localparam logic [15:0] OFF_NUM   = 16'hf010;
    localparam logic [15:0] OFF_SW    = 16'hf020;
    localparam logic [15:0] OFF_TIMER = 16'he000;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

    logic              conf_sel;
    logic [15:0]       conf_off;
    logic [RAM_AW-1:0] ram_idx;
    logic              is_rd;
    logic              is_wr;
    logic              ram_rd;
    logic              ram_wr;
    logic              conf_rd;
    logic              conf_wr;

    assign conf_sel = (sram_addr[31:16] == CONF_BASE);
    assign conf_off = sram_addr[15:0];
    assign ram_idx  = sram_addr[RAM_AW+1:2];
    assign is_rd    = sram_en && (sram_wen == 4'b0000);
    assign is_wr    = sram_en && (sram_wen != 4'b0000);
    // Reset gates every access so a cancelled write never lands in the RAM.
    assign ram_rd   = resetn && is_rd && !conf_sel;
    assign ram_wr   = resetn && is_wr && !conf_sel;
    assign conf_rd  = is_rd && conf_sel;
    assign conf_wr  = is_wr && conf_sel;

    // Single-port RAM with per-lane write enables and a registered output.
    logic [31:0] mem [0:(1<<RAM_AW)-1];
    logic [31:0] ram_q;

    always_ff @(posedge clk) begin
        if (ram_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (sram_wen[i]) mem[ram_idx][8*i +: 8] <= sram_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ram_q <= 32'h0;
        end else if (ram_rd) begin
            ram_q <= mem[ram_idx];
        end
    end

    logic [31:0]     timer_q;
    logic [SW_W-1:0] sw_s1;
    logic [SW_W-1:0] sw_s2;
    logic [31:0]     conf_rdata;
    logic [31:0]     conf_q;
    logic            rd_conf_q;
    logic [15:0]     led_next;
    logic [31:0]     num_next;
    logic [31:0]     timer_next;

    always_comb begin
        conf_rdata = 32'h0;
        case (conf_off)
            OFF_LED:   conf_rdata = {16'h0, led_out};
            OFF_NUM:   conf_rdata = num_out;
            OFF_SW:    conf_rdata = 32'(sw_s2);
            OFF_TIMER: conf_rdata = timer_q;
            default:   conf_rdata = 32'h0;
        endcase
    end

    always_comb begin
        led_next   = led_out;
        num_next   = num_out;
        timer_next = timer_q + 32'd1;
        if (conf_wr) begin
            case (conf_off)
                OFF_LED: begin
                    led_next[7:0]  = sram_wen[0] ? sram_wdata[7:0]  : led_out[7:0];
                    led_next[15:8] = sram_wen[1] ? sram_wdata[15:8] : led_out[15:8];
                end
                OFF_NUM:   num_next   = merge_bytes(num_out, sram_wdata, sram_wen);
                OFF_TIMER: timer_next = merge_bytes(timer_q, sram_wdata, sram_wen);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            led_out   <= 16'h0;
            num_out   <= 32'h0;
            timer_q   <= 32'h0;
            sw_s1     <= '0;
            sw_s2     <= '0;
            conf_q    <= 32'h0;
            rd_conf_q <= 1'b0;
        end else begin
            led_out <= led_next;
            num_out <= num_next;
            timer_q <= timer_next;
            sw_s1   <= switch_in;
            sw_s2   <= sw_s1;
            if (is_rd) rd_conf_q <= conf_sel;
            if (conf_rd) conf_q <= conf_rdata;
        end
    end

    // Both sources are flops; the select remembers which one the last read targeted.
    assign sram_rdata = rd_conf_q ? conf_q : ram_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: directed vector table plus randomized traffic against a reference model.
// Latency: outputs are checked 1 ns after every rising edge.
// Backpressure: none; one access is driven per cycle.
module tb_data_sram_responder;

    logic        clk;
    logic        resetn;
    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic [7:0]  switch_in;
    logic [15:0] led_out;
    logic [31:0] num_out;

    data_sram_responder #(.RAM_AW(12), .CONF_BASE(16'h1faf), .SW_W(8)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .sram_en    (sram_en),
        .sram_wen   (sram_wen),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .switch_in  (switch_in),
        .led_out    (led_out),
        .num_out    (num_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: timer is kept as (value, edge it was set at).
    logic [31:0] m_mem [int];
    logic [15:0] m_led;
    logic [31:0] m_num;
    logic [31:0] t_ref;
    int          t_cyc;
    int          cyc;
    logic [31:0] m_rd;
    bit          rd_known;
    logic [7:0]  sw_h [4096];
    bit          rn_h [4096];

    function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? n[8*i +: 8] : o[8*i +: 8];
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d: got %08h expected %08h", name, cyc, act, exp);
        end
    endtask

    task automatic model(input logic rn, input logic en, input logic [3:0] wen,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [7:0] sw);
        int          c;
        int          idx;
        logic [31:0] cur_t;
        logic [31:0] sync;
        logic [31:0] tmp;
        c = cyc;
        sw_h[c] = sw;
        rn_h[c] = rn;
        cur_t = t_ref + 32'(c - 1 - t_cyc);
        sync = 32'h0;
        if (c >= 2) begin
            if (rn_h[c-1] && rn_h[c-2]) sync = {24'h0, sw_h[c-2]};
        end
        idx = int'(addr[13:2]);
        if (!rn) begin
            m_rd = 32'h0; rd_known = 1; m_led = 16'h0; m_num = 32'h0;
            t_ref = 32'h0; t_cyc = c;
        end else if (en) begin
            if (addr[31:16] == 16'h1faf) begin
                if (wen == 4'h0) begin
                    rd_known = 1;
                    case (addr[15:0])
                        16'hf000: m_rd = {16'h0, m_led};
                        16'hf010: m_rd = m_num;
                        16'hf020: m_rd = sync;
                        16'he000: m_rd = cur_t;
                        default:  m_rd = 32'h0;
                    endcase
                end else begin
                    case (addr[15:0])
                        16'hf000: begin tmp = mrg({16'h0, m_led}, wdata, wen); m_led = tmp[15:0]; end
                        16'hf010: m_num = mrg(m_num, wdata, wen);
                        16'he000: begin t_ref = mrg(cur_t, wdata, wen); t_cyc = c; end
                        default: ;
                    endcase
                end
            end else begin
                if (wen == 4'h0) begin
                    rd_known = m_mem.exists(idx);
                    if (rd_known) m_rd = m_mem[idx];
                end else if (m_mem.exists(idx)) begin
                    m_mem[idx] = mrg(m_mem[idx], wdata, wen);
                end else if (wen == 4'hf) begin
                    m_mem[idx] = wdata;
                end
            end
        end
        cyc++;
    endtask

    task automatic step(input logic rn, input logic en, input logic [3:0] wen,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [7:0] sw);
        @(negedge clk);
        resetn = rn; sram_en = en; sram_wen = wen; sram_addr = addr; sram_wdata = wdata; switch_in = sw;
        model(rn, en, wen, addr, wdata, sw);
        @(posedge clk);
        #1;
        if (rd_known) check("model_rdata", sram_rdata, m_rd);
        check("model_led", {16'h0, led_out}, {16'h0, m_led});
        check("model_num", num_out, m_num);
    endtask

    typedef struct {
        logic        rn;
        logic        en;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [7:0]  sw;
        logic [31:0] exp;
        string       name;
    } vec_t;
    vec_t tv [$];

    initial begin
        m_led = 0; m_num = 0; t_ref = 0; t_cyc = 0; cyc = 0; m_rd = 0; rd_known = 0;
        resetn = 0; sram_en = 0; sram_wen = 0; sram_addr = 0; sram_wdata = 0; switch_in = 0;

        tv.push_back('{1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        8'h00, 32'h0,        "reset_rdata"});
        tv.push_back('{1'b1, 1'b1, 4'hf, 32'h00000010, 32'hdeadbeef, 8'h00, 32'h0,        "wr_holds_zero"});
        tv.push_back('{1'b1, 1'b1, 4'h0, 32'h00000010, 32'h0,        8'h00, 32'hdeadbeef, "word_rd"});
        tv.push_back('{1'b1, 1'b1, 4'hf, 32'h00000020, 32'h11223344, 8'h00, 32'hdeadbeef, "wr_holds"});
        tv.push_back('{1'b1, 1'b1, 4'h5, 32'h00000020, 32'haabbccdd, 8'h00, 32'hdeadbeef, "lane_wr_holds"});
        tv.push_back('{1'b1, 1'b1, 4'h0, 32'h00000020, 32'h0,        8'h00, 32'h11bb33dd, "byte_lanes"});
        tv.push_back('{1'b1, 1'b1, 4'h0, 32'h00000020, 32'h0,        8'h00, 32'h11bb33dd, "byte_lanes_again"});
        tv.push_back('{1'b1, 1'b1, 4'h0, 32'h00004010, 32'h0,        8'h00, 32'hdeadbeef, "alias"});
        tv.push_back('{1'b1, 1'b1, 4'hf, 32'h1fafe000, 32'h00000100, 8'h00, 32'hdeadbeef, "timer_wr"});
        for (int i = 0; i < 4; i++)
            tv.push_back('{1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 8'h00, 32'hdeadbeef, "idle_hold"});
        tv.push_back('{1'b1, 1'b1, 4'h0, 32'h1fafe000, 32'h0,        8'h00, 32'h00000104, "timer_rd_5"});
        tv.push_back('{1'b1, 1'b1, 4'hf, 32'h1faff000, 32'hffffffff, 8'h00, 32'h00000104, "led_wr"});
        tv.push_back('{1'b1, 1'b1, 4'h0, 32'h1faff000, 32'h0,        8'h00, 32'h0000ffff, "led_rd"});
        tv.push_back('{1'b1, 1'b1, 4'hf, 32'h1faff020, 32'h12345678, 8'h5a, 32'h0000ffff, "sw_wr_ignored"});
        tv.push_back('{1'b1, 1'b0, 4'h0, 32'h0,        32'h0,        8'h5a, 32'h0000ffff, "sw_hold"});
        tv.push_back('{1'b1, 1'b1, 4'h0, 32'h1faff020, 32'h0,        8'h5a, 32'h0000005a, "sw_rd"});
        tv.push_back('{1'b1, 1'b1, 4'h0, 32'h1faff100, 32'h0,        8'h00, 32'h0,        "other_off"});
        tv.push_back('{1'b1, 1'b1, 4'hf, 32'h1fafe000, 32'hffffffff, 8'h00, 32'h0,        "timer_wr_max"});
        tv.push_back('{1'b1, 1'b1, 4'h0, 32'h1fafe000, 32'h0,        8'h00, 32'hffffffff, "timer_max"});
        tv.push_back('{1'b1, 1'b1, 4'h0, 32'h1fafe000, 32'h0,        8'h00, 32'h0,        "timer_wrap"});
        tv.push_back('{1'b1, 1'b1, 4'hf, 32'h1faff010, 32'h12345678, 8'h00, 32'h0,        "num_wr"});
        tv.push_back('{1'b1, 1'b1, 4'h0, 32'h1faff010, 32'h0,        8'h00, 32'h12345678, "num_rd"});
        tv.push_back('{1'b0, 1'b1, 4'hf, 32'h1faff010, 32'hcafef00d, 8'h00, 32'h0,        "rst_mid_wr"});
        tv.push_back('{1'b1, 1'b1, 4'h0, 32'h00000010, 32'h0,        8'h00, 32'hdeadbeef, "ram_survives"});
        tv.push_back('{1'b1, 1'b1, 4'h0, 32'h1faff010, 32'h0,        8'h00, 32'h0,        "num_after_rst"});
        tv.push_back('{1'b1, 1'b1, 4'h0, 32'h1fafe000, 32'h0,        8'h00, 32'h00000002, "timer_after_rst"});

        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 8'h00);

        foreach (tv[i]) begin
            step(tv[i].rn, tv[i].en, tv[i].wen, tv[i].addr, tv[i].wdata, tv[i].sw);
            check(tv[i].name, sram_rdata, tv[i].exp);
            if (tv[i].name == "reset_rdata" || tv[i].name == "rst_mid_wr") begin
                check({tv[i].name, "_led"}, {16'h0, led_out}, 32'h0);
                check({tv[i].name, "_num"}, num_out, 32'h0);
            end
            if (tv[i].name == "led_wr") check("led_out", {16'h0, led_out}, 32'h0000ffff);
        end

        for (int i = 0; i < 16; i++)
            step(1'b1, 1'b1, 4'hf, 32'(i) << 2, $urandom(), 8'($urandom()));

        for (int i = 0; i < 1500; i++) begin
            logic        rn;
            logic        en;
            logic [3:0]  wen;
            logic [31:0] addr;
            rn  = ($urandom_range(0, 49) != 0);
            en  = ($urandom_range(0, 3) != 0);
            wen = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            if ($urandom_range(0, 9) < 6) begin
                addr = ($urandom() & 32'h0fffc03c) | 32'($urandom_range(0, 3));
            end else begin
                case ($urandom_range(0, 4))
                    0: addr = 32'h1faff000;
                    1: addr = 32'h1faff010;
                    2: addr = 32'h1faff020;
                    3: addr = 32'h1fafe000;
                    default: addr = 32'h1faf0000 | 32'($urandom_range(0, 16'h0fff));
                endcase
            end
            step(rn, en, wen, addr, $urandom(), 8'($urandom()));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, got cycle %0d expected completion", cyc);
        $fatal(1, "timeout");
    end

endmodule
